// File: rtl/ai_ram_pkg.sv
// Shared definitions for the AI RAM stream loader: FSM encoding, default lane
// geometry matching the RAM, and the empty-to-byte-enable helper.
package ai_ram_pkg;

  // Loader FSM encoding
  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StRun  = 2'd1;
  localparam logic [1:0] StDrop = 2'd2;

  // Default beat geometry shared with the AI RAM
  localparam int unsigned DefaultLanes = 4;
  localparam int unsigned DefaultLaneW = 8;

  // Byte enable for one lane of an eop beat. An out-of-range empty is clamped
  // to lanes-1 so at least lane 0 is always written.
  function automatic logic lane_enable(int unsigned lane, int unsigned lanes,
                                       int unsigned empty);
    int unsigned eff;
    eff = (empty >= lanes) ? lanes - 1 : empty;
    return lane < (lanes - eff);
  endfunction

endpackage

// File: rtl/ai_ram_wr_stage.sv
// Single-slot registered RAM write stage. A loaded word is presented on the
// q_* outputs and held until the RAM accepts it (q_write && !q_waitrequest).
module ai_ram_wr_stage #(
  parameter int unsigned ADDR_W = 14,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned LANES  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data,
  input  logic [LANES-1:0]  load_be,
  input  logic              q_waitrequest,
  output logic              ready,
  output logic              q_write,
  output logic [ADDR_W-1:0] q_addr,
  output logic [DATA_W-1:0] q_data,
  output logic [LANES-1:0]  q_be
);

  // Slot is free when empty or draining this cycle; never ready in reset.
  assign ready = !rst && (!q_write || !q_waitrequest);

  // Load a new word, retire a completed one, or hold under waitrequest.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_write <= 1'b0;
      q_addr  <= '0;
      q_data  <= '0;
      q_be    <= '0;
    end else if (load) begin
      q_write <= 1'b1;
      q_addr  <= load_addr;
      q_data  <= load_data;
      q_be    <= load_be;
    end else if (!q_waitrequest) begin
      q_write <= 1'b0;
    end
  end

endmodule

// File: rtl/ai_ram_avst_loader_p.sv
// Avalon-ST sink that stores each packet contiguously from address 0 of the
// AI RAM, one beat per cycle, with backpressure, byte enables, word count
// and sticky orphan/overflow error flags.
module ai_ram_avst_loader_p
  import ai_ram_pkg::*;
#(
  parameter int unsigned LANES   = DefaultLanes,
  parameter int unsigned LANE_W  = DefaultLaneW,
  parameter int unsigned ADDR_W  = 14,
  parameter int unsigned EMPTY_W = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [LANES*LANE_W-1:0] avs_s4_data,
  input  logic                    avs_s4_valid,
  input  logic                    avs_s4_startofpacket,
  input  logic                    avs_s4_endofpacket,
  input  logic [EMPTY_W-1:0]      avs_s4_empty,
  output logic                    avs_s4_ready,
  output logic [ADDR_W-1:0]       q_addr,
  output logic                    q_write,
  output logic [LANES*LANE_W-1:0] q_data,
  output logic [LANES-1:0]        q_be,
  input  logic                    q_waitrequest,
  output logic                    pkt_done,
  output logic [ADDR_W:0]         pkt_words,
  output logic                    err_nosop,
  output logic                    err_overflow,
  input  logic                    clr_err
);

  localparam int unsigned DataW = LANES * LANE_W;

  logic [1:0]        state_q, state_d;
  // One bit wider than the address so a full-memory packet can be counted
  // and the next beat recognised as an overflow.
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic              done_q, done_d;
  logic [ADDR_W:0]   words_q, words_d;
  logic              nosop_q, ovf_q;
  logic              set_nosop, set_ovf;
  logic              ready, accept;
  logic              wr_load;
  logic [ADDR_W-1:0] wr_addr;
  logic [LANES-1:0]  eop_be, wr_be;
  logic [31:0]       empty_ext;

  assign accept    = avs_s4_valid && ready;
  assign empty_ext = 32'(avs_s4_empty);

  // Lane mask used on the eop beat; empty is ignored on other beats.
  always_comb begin
    eop_be = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      eop_be[i] = lane_enable(i, LANES, empty_ext);
    end
  end

  assign wr_be = avs_s4_endofpacket ? eop_be : '1;

  // Packet FSM: decides whether an accepted beat is written, where, and
  // which status events it raises.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    done_d    = 1'b0;
    words_d   = words_q;
    set_nosop = 1'b0;
    set_ovf   = 1'b0;
    wr_load   = 1'b0;
    wr_addr   = cnt_q[ADDR_W-1:0];

    if (accept) begin
      if (avs_s4_startofpacket) begin
        // A sop always (re)starts a packet at address 0, in any state.
        wr_load = 1'b1;
        wr_addr = '0;
        if (avs_s4_endofpacket) begin
          done_d  = 1'b1;
          words_d = {{ADDR_W{1'b0}}, 1'b1};
          cnt_d   = '0;
          state_d = StIdle;
        end else begin
          cnt_d   = {{ADDR_W{1'b0}}, 1'b1};
          state_d = StRun;
        end
      end else begin
        unique case (state_q)
          StIdle: begin
            set_nosop = 1'b1;
            state_d   = avs_s4_endofpacket ? StIdle : StDrop;
          end
          StRun: begin
            if (cnt_q[ADDR_W]) begin
              // Memory already full: drop the rest of this packet.
              set_ovf = 1'b1;
              cnt_d   = '0;
              state_d = avs_s4_endofpacket ? StIdle : StDrop;
            end else begin
              wr_load = 1'b1;
              if (avs_s4_endofpacket) begin
                done_d  = 1'b1;
                words_d = cnt_q + 1'b1;
                cnt_d   = '0;
                state_d = StIdle;
              end else begin
                cnt_d = cnt_q + 1'b1;
              end
            end
          end
          StDrop: begin
            state_d = avs_s4_endofpacket ? StIdle : StDrop;
          end
          default: begin
            state_d = StIdle;
            cnt_d   = '0;
          end
        endcase
      end
    end
  end

  // State, counters, status pulse and sticky errors (set wins over clear).
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      words_q <= '0;
      nosop_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      words_q <= words_d;
      nosop_q <= set_nosop | (nosop_q & ~clr_err);
      ovf_q   <= set_ovf | (ovf_q & ~clr_err);
    end
  end

  ai_ram_wr_stage #(
    .ADDR_W (ADDR_W),
    .DATA_W (DataW),
    .LANES  (LANES)
  ) u_wr_stage (
    .clk           (clk),
    .rst           (rst),
    .load          (wr_load),
    .load_addr     (wr_addr),
    .load_data     (avs_s4_data),
    .load_be       (wr_be),
    .q_waitrequest (q_waitrequest),
    .ready         (ready),
    .q_write       (q_write),
    .q_addr        (q_addr),
    .q_data        (q_data),
    .q_be          (q_be)
  );

  assign avs_s4_ready = ready;
  assign pkt_done     = done_q;
  assign pkt_words    = words_q;
  assign err_nosop    = nosop_q;
  assign err_overflow = ovf_q;

endmodule

// File: tb/tb_ai_ram_avst_loader_p.sv
// Directed bench for ai_ram_avst_loader_p with a small (ADDR_W=3) memory so
// the overflow and full-memory boundaries are reachable.
module tb_ai_ram_avst_loader_p;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] avs_data = '0;
  logic        valid = 1'b0;
  logic        sop = 1'b0;
  logic        eop = 1'b0;
  logic [1:0]  empty = '0;
  logic        avs_s4_ready;
  logic [2:0]  q_addr;
  logic        q_write;
  logic [31:0] q_data;
  logic [3:0]  q_be;
  logic        q_waitrequest = 1'b0;
  logic        pkt_done;
  logic [3:0]  pkt_words;
  logic        err_nosop;
  logic        err_overflow;
  logic        clr_err = 1'b0;

  int errors = 0;
  int checks = 0;

  // Write log and event counters, written only by the monitor below.
  logic [2:0]  log_addr[$];
  logic [31:0] log_data[$];
  logic [3:0]  log_be[$];
  int          log_cyc[$];
  int          cyc = 0;
  int          done_cnt = 0;
  int          done_nowrite = 0;
  int          ready_low = 0;
  int          addr1_cyc = 0;
  logic [3:0]  last_words = '0;

  ai_ram_avst_loader_p #(
    .LANES   (4),
    .LANE_W  (8),
    .ADDR_W  (3),
    .EMPTY_W (2)
  ) dut (
    .clk                  (clk),
    .rst                  (rst),
    .avs_s4_data          (avs_data),
    .avs_s4_valid         (valid),
    .avs_s4_startofpacket (sop),
    .avs_s4_endofpacket   (eop),
    .avs_s4_empty         (empty),
    .avs_s4_ready         (avs_s4_ready),
    .q_addr               (q_addr),
    .q_write              (q_write),
    .q_data               (q_data),
    .q_be                 (q_be),
    .q_waitrequest        (q_waitrequest),
    .pkt_done             (pkt_done),
    .pkt_words            (pkt_words),
    .err_nosop            (err_nosop),
    .err_overflow         (err_overflow),
    .clr_err              (clr_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Observe on the falling edge, when every input and output is settled.
  always @(negedge clk) begin
    if (q_write && !q_waitrequest) begin
      log_addr.push_back(q_addr);
      log_data.push_back(q_data);
      log_be.push_back(q_be);
      log_cyc.push_back(cyc);
    end
    if (pkt_done) begin
      done_cnt   <= done_cnt + 1;
      last_words <= pkt_words;
      if (!q_write) done_nowrite <= done_nowrite + 1;
    end
    if (!avs_s4_ready && !rst) ready_low <= ready_low + 1;
    if (q_write && q_addr == 3'd1) addr1_cyc <= addr1_cyc + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Present one beat and hold it until accepted (bounded).
  task automatic send_beat(input logic [31:0] d, input logic s, input logic e,
                           input logic [1:0] em);
    int n;
    avs_data = d; sop = s; eop = e; empty = em; valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!avs_s4_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!avs_s4_ready) begin
      checks++; errors++;
      $display("FAIL handshake: ready=%0b after %0d cycles, required 1", avs_s4_ready, n);
    end
    @(posedge clk);
    #1;
    valid = 1'b0; sop = 1'b0; eop = 1'b0; empty = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle(3);
    checks++;
    if (avs_s4_ready !== 1'b0) begin
      errors++; $display("FAIL reset_ready: got %0b required 0", avs_s4_ready);
    end
    checks++;
    if ({q_write, q_addr, q_data, q_be} !== '0) begin
      errors++;
      $display("FAIL reset_wr: write=%0b addr=%0d data=%h be=%h required all 0",
               q_write, q_addr, q_data, q_be);
    end
    checks++;
    if ({pkt_done, pkt_words, err_nosop, err_overflow} !== '0) begin
      errors++;
      $display("FAIL reset_status: done=%0b words=%0d nosop=%0b ovf=%0b required all 0",
               pkt_done, pkt_words, err_nosop, err_overflow);
    end
    rst = 1'b0;
    idle(1);
    checks++;
    if (avs_s4_ready !== 1'b1) begin
      errors++; $display("FAIL reset_release_ready: got %0b required 1", avs_s4_ready);
    end
  endtask

  task automatic test_four_beat();
    int b, bd, br;
    b = log_addr.size(); bd = done_cnt; br = ready_low;
    for (int i = 0; i < 4; i++) send_beat(32'hA0A0_0000 + 32'(i), i == 0, i == 3, 2'd0);
    idle(3);
    checks++;
    if (log_addr.size() - b != 4) begin
      errors++; $display("FAIL four_count: got %0d writes required 4", log_addr.size() - b);
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (log_addr[b+i] !== 3'(i) || log_data[b+i] !== 32'hA0A0_0000 + 32'(i) ||
            log_be[b+i] !== 4'hF || log_cyc[b+i] != log_cyc[b] + i) begin
          errors++;
          $display("FAIL four_write%0d: addr=%0d data=%h be=%h cyc+%0d required %0d %h f +%0d",
                   i, log_addr[b+i], log_data[b+i], log_be[b+i], log_cyc[b+i] - log_cyc[b],
                   i, 32'hA0A0_0000 + 32'(i), i);
        end
      end
    end
    checks++;
    if (done_cnt - bd != 1 || last_words !== 4'd4) begin
      errors++;
      $display("FAIL four_done: pulses=%0d words=%0d required 1 and 4", done_cnt - bd, last_words);
    end
    checks++;
    if (ready_low != br) begin
      errors++; $display("FAIL four_ready: low cycles=%0d required 0", ready_low - br);
    end
  endtask

  task automatic test_single();
    int b, bd;
    b = log_addr.size(); bd = done_cnt;
    send_beat(32'hAABBCCDD, 1'b1, 1'b1, 2'd3);
    idle(3);
    checks++;
    if (log_addr.size() - b != 1) begin
      errors++; $display("FAIL single_count: got %0d writes required 1", log_addr.size() - b);
    end else begin
      checks++;
      if (log_addr[b] !== 3'd0 || log_data[b] !== 32'hAABBCCDD || log_be[b] !== 4'b0001) begin
        errors++;
        $display("FAIL single_write: addr=%0d data=%h be=%b required 0 aabbccdd 0001",
                 log_addr[b], log_data[b], log_be[b]);
      end
    end
    checks++;
    if (done_cnt - bd != 1 || last_words !== 4'd1) begin
      errors++;
      $display("FAIL single_done: pulses=%0d words=%0d required 1 and 1", done_cnt - bd, last_words);
    end
  endtask

  task automatic test_be();
    int b;
    b = log_addr.size();
    send_beat(32'h1111_2222, 1'b1, 1'b0, 2'd2);
    send_beat(32'h3333_4444, 1'b0, 1'b1, 2'd1);
    idle(3);
    checks++;
    if (log_addr.size() - b != 2 || log_be[b] !== 4'hF || log_be[b+1] !== 4'b0111) begin
      errors++;
      $display("FAIL be_mask: writes=%0d be0=%b be1=%b required 2 1111 0111",
               log_addr.size() - b, log_be[b], log_be[b+1]);
    end
  endtask

  task automatic test_stall();
    int b, bd, br, ba;
    b = log_addr.size(); bd = done_cnt; br = ready_low; ba = addr1_cyc;
    fork
      begin
        for (int i = 0; i < 3; i++) send_beat(32'h3000_0000 + 32'(i), i == 0, i == 2, 2'd0);
      end
      begin : staller
        int n;
        n = 0;
        while (!(q_write && q_addr == 3'd1) && n < 50) begin
          @(posedge clk);
          #1;
          n++;
        end
        q_waitrequest = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        q_waitrequest = 1'b0;
      end
    join
    idle(3);
    checks++;
    if (log_addr.size() - b != 3) begin
      errors++; $display("FAIL stall_count: got %0d writes required 3", log_addr.size() - b);
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (log_addr[b+i] !== 3'(i) || log_data[b+i] !== 32'h3000_0000 + 32'(i)) begin
          errors++;
          $display("FAIL stall_write%0d: addr=%0d data=%h required %0d %h", i, log_addr[b+i],
                   log_data[b+i], i, 32'h3000_0000 + 32'(i));
        end
      end
    end
    checks++;
    if (ready_low - br != 2) begin
      errors++; $display("FAIL stall_ready: low cycles=%0d required 2", ready_low - br);
    end
    checks++;
    if (addr1_cyc - ba != 3) begin
      errors++; $display("FAIL stall_hold: addr1 shown %0d cycles required 3", addr1_cyc - ba);
    end
    checks++;
    if (done_cnt - bd != 1 || last_words !== 4'd3) begin
      errors++;
      $display("FAIL stall_done: pulses=%0d words=%0d required 1 and 3", done_cnt - bd, last_words);
    end
  endtask

  task automatic test_nosop();
    int b, bd;
    b = log_addr.size(); bd = done_cnt;
    send_beat(32'hDEAD_0001, 1'b0, 1'b0, 2'd0);
    send_beat(32'hDEAD_0002, 1'b0, 1'b0, 2'd0);
    send_beat(32'hDEAD_0003, 1'b0, 1'b1, 2'd0);
    send_beat(32'h4000_0000, 1'b1, 1'b0, 2'd0);
    send_beat(32'h4000_0001, 1'b0, 1'b1, 2'd0);
    idle(3);
    checks++;
    if (err_nosop !== 1'b1 || err_overflow !== 1'b0) begin
      errors++;
      $display("FAIL nosop_flag: nosop=%0b ovf=%0b required 1 0", err_nosop, err_overflow);
    end
    checks++;
    if (log_addr.size() - b != 2 || log_addr[b] !== 3'd0 || log_data[b] !== 32'h4000_0000 ||
        log_addr[b+1] !== 3'd1 || log_data[b+1] !== 32'h4000_0001) begin
      errors++;
      $display("FAIL nosop_writes: count=%0d first addr=%0d data=%h required 2 0 40000000",
               log_addr.size() - b, log_addr[b], log_data[b]);
    end
    checks++;
    if (done_cnt - bd != 1 || last_words !== 4'd2) begin
      errors++;
      $display("FAIL nosop_done: pulses=%0d words=%0d required 1 and 2", done_cnt - bd, last_words);
    end
    clr_err = 1'b1;
    idle(1);
    clr_err = 1'b0;
    checks++;
    if (err_nosop !== 1'b0) begin
      errors++; $display("FAIL nosop_clear: nosop=%0b required 0", err_nosop);
    end
  endtask

  task automatic test_overflow();
    int b, bd;
    b = log_addr.size(); bd = done_cnt;
    for (int i = 0; i < 10; i++) send_beat(32'h5000_0000 + 32'(i), i == 0, i == 9, 2'd0);
    idle(3);
    checks++;
    if (log_addr.size() - b != 8) begin
      errors++; $display("FAIL ovf_count: got %0d writes required 8", log_addr.size() - b);
    end else begin
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (log_addr[b+i] !== 3'(i) || log_data[b+i] !== 32'h5000_0000 + 32'(i)) begin
          errors++;
          $display("FAIL ovf_write%0d: addr=%0d data=%h required %0d %h", i, log_addr[b+i],
                   log_data[b+i], i, 32'h5000_0000 + 32'(i));
        end
      end
    end
    checks++;
    if (err_overflow !== 1'b1 || err_nosop !== 1'b0) begin
      errors++;
      $display("FAIL ovf_flag: ovf=%0b nosop=%0b required 1 0", err_overflow, err_nosop);
    end
    checks++;
    if (done_cnt != bd) begin
      errors++; $display("FAIL ovf_nodone: pulses=%0d required 0", done_cnt - bd);
    end
    b = log_addr.size();
    send_beat(32'h6000_0000, 1'b1, 1'b0, 2'd0);
    send_beat(32'h6000_0001, 1'b0, 1'b1, 2'd0);
    idle(3);
    checks++;
    if (log_addr.size() - b != 2 || log_addr[b] !== 3'd0 || log_addr[b+1] !== 3'd1 ||
        log_data[b+1] !== 32'h6000_0001) begin
      errors++;
      $display("FAIL ovf_next_writes: count=%0d addr0=%0d addr1=%0d required 2 0 1",
               log_addr.size() - b, log_addr[b], log_addr[b+1]);
    end
    checks++;
    if (done_cnt - bd != 1 || last_words !== 4'd2) begin
      errors++;
      $display("FAIL ovf_next_done: pulses=%0d words=%0d required 1 and 2",
               done_cnt - bd, last_words);
    end
    clr_err = 1'b1;
    idle(1);
    clr_err = 1'b0;
    checks++;
    if (err_overflow !== 1'b0) begin
      errors++; $display("FAIL ovf_clear: ovf=%0b required 0", err_overflow);
    end
  endtask

  task automatic test_full();
    int b, bd;
    b = log_addr.size(); bd = done_cnt;
    for (int i = 0; i < 8; i++) send_beat(32'h8000_0000 + 32'(i), i == 0, i == 7, 2'd0);
    idle(3);
    checks++;
    if (log_addr.size() - b != 8 || log_addr[b+7] !== 3'd7 || err_overflow !== 1'b0) begin
      errors++;
      $display("FAIL full_writes: count=%0d last addr=%0d ovf=%0b required 8 7 0",
               log_addr.size() - b, log_addr[b+7], err_overflow);
    end
    checks++;
    if (done_cnt - bd != 1 || last_words !== 4'd8) begin
      errors++;
      $display("FAIL full_done: pulses=%0d words=%0d required 1 and 8", done_cnt - bd, last_words);
    end
  endtask

  task automatic test_restart();
    int b, bd;
    logic [2:0] ea[5];
    ea = '{3'd0, 3'd1, 3'd0, 3'd1, 3'd2};
    b = log_addr.size(); bd = done_cnt;
    send_beat(32'h9000_0000, 1'b1, 1'b0, 2'd0);
    send_beat(32'h9000_0001, 1'b0, 1'b0, 2'd0);
    send_beat(32'h9000_0002, 1'b1, 1'b0, 2'd0);
    send_beat(32'h9000_0003, 1'b0, 1'b0, 2'd0);
    send_beat(32'h9000_0004, 1'b0, 1'b1, 2'd0);
    idle(3);
    checks++;
    if (log_addr.size() - b != 5) begin
      errors++; $display("FAIL restart_count: got %0d writes required 5", log_addr.size() - b);
    end else begin
      for (int i = 0; i < 5; i++) begin
        checks++;
        if (log_addr[b+i] !== ea[i] || log_data[b+i] !== 32'h9000_0000 + 32'(i)) begin
          errors++;
          $display("FAIL restart_write%0d: addr=%0d data=%h required %0d %h", i, log_addr[b+i],
                   log_data[b+i], ea[i], 32'h9000_0000 + 32'(i));
        end
      end
    end
    checks++;
    if (done_cnt - bd != 1 || last_words !== 4'd3 || err_nosop !== 1'b0) begin
      errors++;
      $display("FAIL restart_done: pulses=%0d words=%0d nosop=%0b required 1 3 0",
               done_cnt - bd, last_words, err_nosop);
    end
  endtask

  task automatic test_mid_reset();
    int b, bd;
    bd = done_cnt;
    send_beat(32'h7700_0000, 1'b1, 1'b0, 2'd0);
    send_beat(32'h7700_0001, 1'b0, 1'b0, 2'd0);
    rst = 1'b1;
    idle(1);
    checks++;
    if ({avs_s4_ready, q_write, q_addr, q_data, q_be, pkt_done, pkt_words} !== '0) begin
      errors++;
      $display("FAIL midrst_outputs: ready=%0b write=%0b addr=%0d data=%h be=%h words=%0d",
               avs_s4_ready, q_write, q_addr, q_data, q_be, pkt_words);
    end
    idle(1);
    rst = 1'b0;
    b = log_addr.size();
    send_beat(32'h7800_0000, 1'b1, 1'b0, 2'd0);
    send_beat(32'h7800_0001, 1'b0, 1'b1, 2'd0);
    idle(3);
    checks++;
    if (log_addr.size() - b != 2 || log_addr[b] !== 3'd0 || log_addr[b+1] !== 3'd1 ||
        log_data[b] !== 32'h7800_0000) begin
      errors++;
      $display("FAIL midrst_writes: count=%0d addr0=%0d addr1=%0d data0=%h required 2 0 1 78000000",
               log_addr.size() - b, log_addr[b], log_addr[b+1], log_data[b]);
    end
    checks++;
    if (done_cnt - bd != 1 || last_words !== 4'd2) begin
      errors++;
      $display("FAIL midrst_done: pulses=%0d words=%0d required 1 and 2", done_cnt - bd, last_words);
    end
  endtask

  initial begin
    test_reset();
    test_four_beat();
    test_single();
    test_be();
    test_stall();
    test_nosop();
    test_overflow();
    test_full();
    test_restart();
    test_mid_reset();
    checks++;
    if (done_nowrite != 0) begin
      errors++;
      $display("FAIL done_with_write: pulses without q_write=%0d required 0", done_nowrite);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
